// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline-control definitions: controller state encoding and the
// control word loaded into ID/EXE when a bubble is inserted.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam int unsigned CTRL_W = 8;
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_stall_controller.sv
// Turns hazard, branch and memory-wait conditions into stage-level freeze,
// bubble and flush controls; watchdogs memory waits and counts stalls/flushes.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_exe,
  output logic             flush,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MAX_WAIT) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WC_W-1:0] r_wait_cnt;
  logic [WC_W-1:0] w_wait_cnt_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;
  logic            w_resolve;
  logic            w_freeze_front;
  logic            w_bubble_exe;
  logic            w_flush;
  logic            w_freeze_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    w_resolve      = 1'b0;
    w_freeze_front = 1'b0;
    w_bubble_exe   = 1'b0;
    w_flush        = 1'b0;
    w_freeze_all   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          w_freeze_all   = 1'b1;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end else begin
          w_resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          w_freeze_all   = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
          if (r_wait_cnt == WC_W'(MAX_WAIT - 1)) begin
            w_state_nxt   = ST_HALT;
            w_timeout_nxt = 1'b1;
          end
        end else begin
          // Branch/hazard held by the frozen pipeline is acted on now.
          w_resolve      = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_HALT: begin
        w_freeze_all = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // A taken branch discards the hazarding instruction, so it wins.
    if (w_resolve) begin
      w_flush        = branch_taken;
      w_freeze_front = !branch_taken && hazard_stall;
      w_bubble_exe   = !branch_taken && hazard_stall;
    end

    if (rst) begin
      w_freeze_front = 1'b0;
      w_bubble_exe   = 1'b0;
      w_flush        = 1'b0;
      w_freeze_all   = 1'b0;
    end
  end

  assign freeze_front = w_freeze_front;
  assign bubble_exe   = w_bubble_exe;
  assign flush        = w_flush;
  assign freeze_all   = w_freeze_all;
  assign mem_timeout  = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_freeze_front || w_freeze_all),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush),
    .count (flush_count)
  );

endmodule
